// File: rtl/onchip_ram_arb_pkg.sv
// onchip_ram_arb_pkg: shared defaults, master index type and the
// weighted round-robin grant-select function for onchip_ram_arbiter.
// Optional feature macro (used by the top): ONCHIP_RAM_ARB_PERF_EN.
package onchip_ram_arb_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;
   localparam int HOLD_CNT_W = 4;

   // Saturation value of the hold counter.
   localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_SAT = '1;

   // One-bit master index: master 0 is the CPU data port, master 1 is DMA/debug.
   typedef enum logic {
      MST_0 = 1'b0,
      MST_1 = 1'b1
   } master_e;

   typedef struct packed {
      logic    valid;
      master_e idx;
   } grant_t;

   // Pick the master to serve this cycle.
   // With a single requester it simply wins. With both requesting, the
   // last-served master keeps the grant while its streak is shorter than
   // max_hold. A zero hold count means no streak is in progress (after
   // reset or an idle cycle), so the master that was not served last goes
   // first; together with last resetting to master 1 this lets master 0
   // win the very first contended cycle.
   function automatic grant_t grant_select(
      input logic                  req0,
      input logic                  req1,
      input master_e               last,
      input logic [HOLD_CNT_W-1:0] hold_cnt,
      input logic [HOLD_CNT_W-1:0] max_hold
   );
      grant_t g;
      g.valid = req0 | req1;
      g.idx   = MST_0;
      if (req0 & req1) begin
         if ((hold_cnt == '0) || (hold_cnt >= max_hold)) begin
            g.idx = (last == MST_0) ? MST_1 : MST_0;
         end else begin
            g.idx = last;
         end
      end else if (req1) begin
         g.idx = MST_1;
      end
      return g;
   endfunction

endpackage

// File: rtl/onchip_ram_arb_rr.sv
// onchip_ram_arb_rr: weighted round-robin grant generator. Holds the
// last-granted master and the length of its current grant streak.
// The grant is combinational; i_stall (reset request) suppresses grants
// and freezes the state.
module onchip_ram_arb_rr
   import onchip_ram_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4   // legal range 1..15
) (
   input  logic clk,
   input  logic reset,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_stall,
   output logic o_gnt_valid,
   output logic o_gnt_idx
);

   localparam logic [HOLD_CNT_W-1:0] MAX_HOLD_C = HOLD_CNT_W'(MAX_HOLD);

   master_e               r_last;
   logic [HOLD_CNT_W-1:0] r_hold_cnt;
   grant_t                w_gnt;
   logic                  w_gnt_fire;

   // Grant decision for the current cycle from requests and streak state.
   always_comb begin
      w_gnt = grant_select(i_req0, i_req1, r_last, r_hold_cnt, MAX_HOLD_C);
   end

   // No grant is issued while in reset or while a reset request stalls the bus.
   assign w_gnt_fire  = w_gnt.valid & ~i_stall & ~reset;
   assign o_gnt_valid = w_gnt_fire;
   assign o_gnt_idx   = w_gnt.idx;

   // Track the streak: extend it on a repeat grant, restart it on a switch,
   // clear it on an idle cycle; hold everything during a reset request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last     <= MST_1;
         r_hold_cnt <= '0;
      end else if (!i_stall) begin
         if (w_gnt.valid) begin
            if (w_gnt.idx == r_last) begin
               if (r_hold_cnt != HOLD_CNT_SAT) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end else begin
               r_hold_cnt <= HOLD_CNT_W'(1);
               r_last     <= w_gnt.idx;
            end
         end else begin
            r_hold_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// onchip_ram_arbiter: shares one single-port on-chip RAM (registered
// address, read latency 1) between two Avalon-MM masters. One access is
// granted per cycle by onchip_ram_arb_rr; read data is routed back with
// readdatavalid qualified by the issuing master.
// Optional feature macro: ONCHIP_RAM_ARB_PERF_EN adds per-master 32-bit
// saturating stall counters (perf_stall0/1) cleared by perf_clear.
module onchip_ram_arbiter
   import onchip_ram_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                reset_req,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
`ifdef ONCHIP_RAM_ARB_PERF_EN
   input  logic                perf_clear,
   output logic [31:0]         perf_stall0,
   output logic [31:0]         perf_stall1,
`endif
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   logic [1:0] w_req;
   logic [1:0] w_sel;
   logic [1:0] w_wait;
   logic [1:0] w_rdv;
   logic       w_gnt_valid;
   logic       w_gnt_idx;
   logic       w_sel_read;
   logic       w_sel_write;
   logic       w_rd_start;
   logic       r_rd_pend;
   logic       r_rd_owner;

   assign w_req[0] = m0_read | m0_write;
   assign w_req[1] = m1_read | m1_write;

   onchip_ram_arb_rr #(
      .MAX_HOLD (MAX_HOLD)
   ) u_rr (
      .clk         (clk),
      .reset       (reset),
      .i_req0      (w_req[0]),
      .i_req1      (w_req[1]),
      .i_stall     (reset_req),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_idx   (w_gnt_idx)
   );

   // Per-master select, stall and read-valid qualification. While in reset
   // every requester is stalled and any in-flight read return is dropped.
   for (genvar gi = 0; gi < 2; gi++) begin : g_mst
      assign w_sel[gi]  = w_gnt_valid & (w_gnt_idx == 1'(gi));
      assign w_wait[gi] = reset ? w_req[gi] : ((w_req[gi] & ~w_sel[gi]) | reset_req);
      assign w_rdv[gi]  = r_rd_pend & (r_rd_owner == 1'(gi)) & ~reset;
   end

   assign m0_waitrequest   = w_wait[0];
   assign m1_waitrequest   = w_wait[1];
   assign m0_readdatavalid = w_rdv[0];
   assign m1_readdatavalid = w_rdv[1];

   // Read data fans out to both masters; only readdatavalid tells them apart.
   assign m0_readdata = mem_readdata;
   assign m1_readdata = mem_readdata;

   // Memory-side mux of the granted master's fields.
   assign w_sel_read     = w_gnt_idx ? m1_read : m0_read;
   assign w_sel_write    = w_gnt_idx ? m1_write : m0_write;
   assign mem_address    = w_gnt_idx ? m1_address : m0_address;
   assign mem_byteenable = w_gnt_idx ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = w_gnt_idx ? m1_writedata : m0_writedata;
   assign mem_chipselect = w_gnt_valid;
   assign mem_write      = w_gnt_valid & w_sel_write;
   assign mem_clken      = reset | ~reset_req;

   // A read and write asserted together is treated as a write.
   assign w_rd_start = w_gnt_valid & w_sel_read & ~w_sel_write;

   // Remember for exactly one cycle that a read was issued and by whom.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_pend  <= 1'b0;
         r_rd_owner <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_start;
         if (w_rd_start) begin
            r_rd_owner <= w_gnt_idx;
         end
      end
   end

   // The RAM's q is frozen by mem_clken=0, so a reset request must never
   // coincide with a read return.
   a_no_rstreq_with_rd_pend : assert property (
      @(posedge clk) disable iff (reset) !(reset_req && r_rd_pend)
   );

`ifdef ONCHIP_RAM_ARB_PERF_EN
   logic [31:0] w_stall_cnt [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] r_cnt;

      // Count cycles this master is requesting but stalled; saturate at max.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_cnt <= '0;
         end else if (perf_clear) begin
            r_cnt <= '0;
         end else if (w_req[gi] & w_wait[gi] & (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
         end
      end

      assign w_stall_cnt[gi] = r_cnt;
   end

   assign perf_stall0 = w_stall_cnt[0];
   assign perf_stall1 = w_stall_cnt[1];
`endif

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// tb_onchip_ram_arbiter: directed, table-driven bench for onchip_ram_arbiter
// with a behavioural 1024x32 byte-enabled RAM (registered address).
module tb_onchip_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        reset_req;
   logic [9:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_readdata;
`ifdef ONCHIP_RAM_ARB_PERF_EN
   logic        perf_clear;
   logic [31:0] perf_stall0, perf_stall1;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   onchip_ram_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .reset_req        (reset_req),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
`ifdef ONCHIP_RAM_ARB_PERF_EN
      .perf_clear       (perf_clear),
      .perf_stall0      (perf_stall0),
      .perf_stall1      (perf_stall1),
`endif
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   // Behavioural RAM: address registered on clken, q unregistered.
   logic [31:0] ram [1024];
   logic [9:0]  ram_addr_q;

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      ram_addr_q = '0;
   end

   always @(posedge clk) begin
      if (mem_clken) begin
         ram_addr_q <= mem_address;
         if (mem_chipselect && mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
         end
      end
   end

   assign mem_readdata = ram[ram_addr_q];

   typedef struct packed {
      logic        r0, w0;
      logic [9:0]  a0;
      logic [3:0]  b0;
      logic [31:0] d0;
      logic        r1, w1;
      logic [9:0]  a1;
      logic [3:0]  b1;
      logic [31:0] d1;
      logic        ew0, ew1, ev0, ev1, ecs;
      logic [31:0] erd;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic r0, input logic w0, input logic [9:0] a0, input logic [3:0] b0, input logic [31:0] d0,
      input logic r1, input logic w1, input logic [9:0] a1, input logic [3:0] b1, input logic [31:0] d1,
      input logic ew0, input logic ew1, input logic ev0, input logic ev1, input logic ecs,
      input logic [31:0] erd);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.b0 = b0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.b1 = b1; v.d1 = d1;
      v.ew0 = ew0; v.ew1 = ew1; v.ev0 = ev0; v.ev1 = ev1; v.ecs = ecs;
      v.erd = erd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
   endtask

   task automatic apply(input vec_t v);
      m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_byteenable = v.b0; m0_writedata = v.d0;
      m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_byteenable = v.b1; m1_writedata = v.d1;
   endtask

   task automatic dual_read();
      m0_read = 1; m0_write = 0; m0_address = 10'h005;
      m1_read = 1; m1_write = 0; m1_address = 10'h020;
   endtask

   int exp_g, prev_g;

   initial begin
      // Vector table: inputs for one cycle and the outputs expected in it.
      //            m0: rd wr addr    be     data           m1: rd wr addr    be     data          w0 w1 v0 v1 cs  rdata
      vecs[0]  = mk(0, 1, 10'h005, 4'hF, 32'hDEADBEEF,  0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 0, 0, 1, 32'h0);
      vecs[1]  = mk(1, 0, 10'h005, 4'hF, 32'h0,         0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 0, 0, 1, 32'h0);
      vecs[2]  = mk(0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 1, 0, 0, 32'hDEADBEEF);
      vecs[3]  = mk(0, 0, 10'h000, 4'hF, 32'h0,         0, 1, 10'h020, 4'hF, 32'h11223344,  0, 0, 0, 0, 1, 32'h0);
      vecs[4]  = mk(0, 0, 10'h000, 4'hF, 32'h0,         0, 1, 10'h020, 4'h2, 32'h0000AB00,  0, 0, 0, 0, 1, 32'h0);
      vecs[5]  = mk(0, 0, 10'h000, 4'hF, 32'h0,         1, 0, 10'h020, 4'hF, 32'h0,         0, 0, 0, 0, 1, 32'h0);
      vecs[6]  = mk(0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 0, 1, 0, 32'h1122AB44);
      vecs[7]  = mk(0, 1, 10'h010, 4'hF, 32'hA5A50010,  0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 0, 0, 1, 32'h0);
      vecs[8]  = mk(0, 0, 10'h000, 4'hF, 32'h0,         0, 1, 10'h3FF, 4'hF, 32'h5A5A03FF,  0, 0, 0, 0, 1, 32'h0);
      vecs[9]  = mk(1, 0, 10'h010, 4'hF, 32'h0,         0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 0, 0, 1, 32'h0);
      vecs[10] = mk(0, 0, 10'h000, 4'hF, 32'h0,         1, 0, 10'h3FF, 4'hF, 32'h0,         0, 0, 1, 0, 1, 32'hA5A50010);
      vecs[11] = mk(0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 0, 1, 0, 32'h5A5A03FF);
      vecs[12] = mk(0, 1, 10'h030, 4'hF, 32'h12345678,  1, 0, 10'h030, 4'hF, 32'h0,         0, 1, 0, 0, 1, 32'h0);
      vecs[13] = mk(0, 0, 10'h000, 4'hF, 32'h0,         1, 0, 10'h030, 4'hF, 32'h0,         0, 0, 0, 0, 1, 32'h0);
      vecs[14] = mk(0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 10'h000, 4'hF, 32'h0,         0, 0, 0, 1, 0, 32'h12345678);

      // Reset state, with m0 requesting to show the stall.
      reset = 1; reset_req = 0;
`ifdef ONCHIP_RAM_ARB_PERF_EN
      perf_clear = 0;
`endif
      set_idle();
      m0_read = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("reset: w0=%b w1=%b cs=%b clken=%b", m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken);
      chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
      chk("rst_wait1", 32'(m1_waitrequest), 32'd0);
      chk("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
      chk("rst_cs", 32'(mem_chipselect), 32'd0);
      chk("rst_clken", 32'(mem_clken), 32'd1);
`ifdef ONCHIP_RAM_ARB_PERF_EN
      chk("rst_perf0", perf_stall0, 32'd0);
      chk("rst_perf1", perf_stall1, 32'd0);
`endif
      set_idle();
      reset = 0;

      // Table-driven single-access traffic.
      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         apply(vecs[i]);
         @(negedge clk);
         $display("vec %0d: w0=%b w1=%b v0=%b v1=%b cs=%b rd=0x%08h", i, m0_waitrequest, m1_waitrequest,
                  m0_readdatavalid, m1_readdatavalid, mem_chipselect, m0_readdata);
         chk($sformatf("v%0d_wait0", i), 32'(m0_waitrequest), 32'(vecs[i].ew0));
         chk($sformatf("v%0d_wait1", i), 32'(m1_waitrequest), 32'(vecs[i].ew1));
         chk($sformatf("v%0d_rdv0", i), 32'(m0_readdatavalid), 32'(vecs[i].ev0));
         chk($sformatf("v%0d_rdv1", i), 32'(m1_readdatavalid), 32'(vecs[i].ev1));
         chk($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(vecs[i].ecs));
         if (vecs[i].ev0) chk($sformatf("v%0d_rdata0", i), m0_readdata, vecs[i].erd);
         if (vecs[i].ev1) chk($sformatf("v%0d_rdata1", i), m1_readdata, vecs[i].erd);
      end

      // Continuous dual reads: windows of four grants, m0 first.
      prev_g = -1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         dual_read();
         @(negedge clk);
         exp_g = (k / 4) % 2;
         $display("dual %0d: w0=%b w1=%b v0=%b v1=%b", k, m0_waitrequest, m1_waitrequest,
                  m0_readdatavalid, m1_readdatavalid);
         chk($sformatf("dual%0d_wait0", k), 32'(m0_waitrequest), 32'(exp_g != 0));
         chk($sformatf("dual%0d_wait1", k), 32'(m1_waitrequest), 32'(exp_g != 1));
         chk($sformatf("dual%0d_cs", k), 32'(mem_chipselect), 32'd1);
         if (prev_g >= 0) begin
            chk($sformatf("dual%0d_rdv0", k), 32'(m0_readdatavalid), 32'(prev_g == 0));
            chk($sformatf("dual%0d_rdv1", k), 32'(m1_readdatavalid), 32'(prev_g == 1));
            chk($sformatf("dual%0d_rdata", k), m0_readdata, (prev_g == 1) ? 32'h1122AB44 : 32'hDEADBEEF);
         end
         prev_g = exp_g;
      end
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      $display("dual tail: v0=%b v1=%b rd=0x%08h", m0_readdatavalid, m1_readdatavalid, m0_readdata);
      chk("dual_tail_rdv0", 32'(m0_readdatavalid), 32'd1);
      chk("dual_tail_rdv1", 32'(m1_readdatavalid), 32'd0);
      chk("dual_tail_rdata", m0_readdata, 32'hDEADBEEF);

      // Reset request: everything stalled, RAM clock gated.
      @(posedge clk); #1;
      reset_req = 1;
      m0_read = 1; m0_address = 10'h005;
      m1_write = 1; m1_address = 10'h040; m1_writedata = 32'hCAFEF00D;
      @(negedge clk);
      $display("reset_req: w0=%b w1=%b cs=%b clken=%b", m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken);
      chk("rreq_wait0", 32'(m0_waitrequest), 32'd1);
      chk("rreq_wait1", 32'(m1_waitrequest), 32'd1);
      chk("rreq_cs", 32'(mem_chipselect), 32'd0);
      chk("rreq_clken", 32'(mem_clken), 32'd0);

      // m1 read granted, then asynchronous reset in the return cycle.
      @(posedge clk); #1;
      reset_req = 0;
      set_idle();
      m1_read = 1; m1_address = 10'h020;
      @(negedge clk);
      $display("pre-reset read: w1=%b clken=%b", m1_waitrequest, mem_clken);
      chk("prerst_wait1", 32'(m1_waitrequest), 32'd0);
      chk("prerst_clken", 32'(mem_clken), 32'd1);
      @(posedge clk); #1;
      reset = 1;
      set_idle();
      m0_read = 1; m1_write = 1; m1_address = 10'h040;
      #1;
      $display("mid-read reset: v1=%b w0=%b w1=%b cs=%b clken=%b", m1_readdatavalid,
               m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken);
      chk("mrst_rdv1", 32'(m1_readdatavalid), 32'd0);
      chk("mrst_wait0", 32'(m0_waitrequest), 32'd1);
      chk("mrst_wait1", 32'(m1_waitrequest), 32'd1);
      chk("mrst_cs", 32'(mem_chipselect), 32'd0);
      chk("mrst_clken", 32'(mem_clken), 32'd1);
      @(negedge clk);
      reset = 0;
      dual_read();
      #1;
      $display("post-reset dual: w0=%b w1=%b", m0_waitrequest, m1_waitrequest);
      chk("prst_wait0", 32'(m0_waitrequest), 32'd0);
      chk("prst_wait1", 32'(m1_waitrequest), 32'd1);
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      $display("post-reset return: v0=%b v1=%b rd=0x%08h", m0_readdatavalid, m1_readdatavalid, m0_readdata);
      chk("prst_rdv0", 32'(m0_readdatavalid), 32'd1);
      chk("prst_rdv1", 32'(m1_readdatavalid), 32'd0);
      chk("prst_rdata", m0_readdata, 32'hDEADBEEF);

`ifdef ONCHIP_RAM_ARB_PERF_EN
      // Stall counters over 10 contended cycles: grants m0 x4, m1 x4, m0 x2.
      @(posedge clk); #1;
      reset = 1;
      @(negedge clk);
      reset = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         dual_read();
      end
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      $display("perf: stall0=%0d stall1=%0d", perf_stall0, perf_stall1);
      chk("perf_stall0", perf_stall0, 32'd4);
      chk("perf_stall1", perf_stall1, 32'd6);
      @(posedge clk); #1;
      perf_clear = 1;
      @(posedge clk); #1;
      perf_clear = 0;
      @(negedge clk);
      $display("perf clear: stall0=%0d stall1=%0d", perf_stall0, perf_stall1);
      chk("perf_clr0", perf_stall0, 32'd0);
      chk("perf_clr1", perf_stall1, 32'd0);
`endif

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
- Two-requester Avalon-MM arbiter that shares one single-port on-chip RAM (1024x32, byte-enabled, registered address, unregistered q, read latency 1) between master 0 (CPU data) and master 1 (DMA/debug).
- Sits between the interconnect and the RAM slave.
- Grants one access per cycle using weighted round-robin: a grant may be held for up to MAX_HOLD consecutive accesses.
- Routes read data back to the issuing master with readdatavalid.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_HOLD, 4, max consecutive grants to one master while the other is requesting; range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- reset_req  in  1  reset request; gates RAM clock enable and stalls both masters
- mN_address  in  ADDR_W  master N word address (N=0,1)
- mN_byteenable  in  DATA_W/8  master N byte enables
- mN_read  in  1  master N read request
- mN_write  in  1  master N write request
- mN_writedata  in  DATA_W  master N write data
- mN_waitrequest  out  1  master N stall
- mN_readdata  out  DATA_W  master N read data
- mN_readdatavalid  out  1  master N read data valid
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  to RAM clock enable
- mem_readdata  in  DATA_W  from RAM, valid 1 cycle after a read cycle

Behaviour:
- Request: reqN = mN_read | mN_write. Read and write asserted together is illegal; write wins.
- Grant is combinational within the cycle. Registered state:
  - last (last-granted master, reset 1 so master 0 wins first)
  - hold_cnt (4 bits, reset 0)
  - rd_pend (reset 0)
  - rd_owner (reset 0)
- Grant selection:
  - Only one requester: it is granted.
  - Both requesting, hold_cnt < MAX_HOLD: grant = last.
  - Both requesting, hold_cnt reaches MAX_HOLD: grant = ~last.
  - On each grant: if grant == last, hold_cnt++ (saturates); otherwise hold_cnt = 1 and last = grant.
  - Idle cycle (no request): hold_cnt = 0; last is unchanged.
- mN_waitrequest = reqN & ~(grant==N) | reset_req. The granted access completes in that cycle; the master sees waitrequest low.
- Memory side:
  - mem_* mux the granted master's fields.
  - mem_chipselect = granted & ~reset_req.
  - mem_write = chipselect & write.
  - mem_clken = ~reset_req.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=grant for the next cycle only.
  - In that next cycle, mN_readdata = mem_readdata and mN_readdatavalid = rd_pend & (rd_owner==N).
  - Back-to-back reads from alternating masters each return exactly 1 cycle after grant; there are no bubbles.
- readdata is driven to both masters at all times; only readdatavalid is qualified.
- reset_req:
  - No grants; hold_cnt is frozen.
  - A read accepted in the previous cycle still returns (rd_pend clears normally), but mem_clken=0 freezes the RAM's q.
  - Therefore reset_req must not be raised with a read outstanding; assertion flags it.
- Asynchronous reset mid-operation:
  - All registers return to reset values immediately; an in-flight readdatavalid is dropped.
  - Outputs during reset: waitrequest = reqN (stall everything), readdatavalid=0, mem_chipselect=0, mem_clken=1.
- Simultaneous write (m0) and read (m1) to the same address: they are serialised by grant; the read sees the write only if granted later.

Optional Feature:
- Macro: ONCHIP_RAM_ARB_PERF_EN.
- With it defined:
  - Adds two 32-bit saturating counters, stallN_cnt: count cycles where reqN & mN_waitrequest.
  - Adds output perf_stall0 / perf_stall1 (32 bits each) and input perf_clear; perf_clear zeroes both counters synchronously.
  - Counters reset to 0.
- Without it: no counters and no perf ports; arbitration behaviour is identical.

Decomposition:
- Package onchip_ram_arb_pkg: ADDR_W/DATA_W defaults, HOLD_CNT_W=4, master-index typedef (1 bit), grant-select function.
- One sub-module: onchip_ram_arb_rr (grant logic + last/hold_cnt registers).
- Muxing and read-return tracking stay in the top module.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x005, be=0xF; m0 reads 0x005 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 with 0xDEADBEEF exactly one cycle after the read grant; m1_readdatavalid stays 0.
- Both masters issue continuous reads, MAX_HOLD=4 -> grant pattern m0 x4, m1 x4, m0 x4; each master's waitrequest high during the other's window; 100% RAM utilisation.
- m1 writes byte enable 0x2 with data 0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.
- Alternating single reads m0@0x010, m1@0x3FF in consecutive cycles -> readdatavalid alternates m0 then m1 on consecutive cycles with the correct data.
- Assert reset mid-read (read granted, reset next edge) -> no readdatavalid, last=1, hold_cnt=0; the next dual request grants m0 first.
- With ONCHIP_RAM_ARB_PERF_EN: 10 cycles of dual requests, MAX_HOLD=1 -> stall0_cnt=5, stall1_cnt=5; perf_clear -> both 0.
